// File: rtl/decn_scan_if.sv
// Control/status bundle for the decn_scan one-hot decoder and scan sequencer.
// master drives the controls and observes the decoded outputs; slave is the decoder.
interface decn_scan_if #(
    parameter int N          = 3,
    parameter int PRESCALE_W = 8
);
    logic                  en;
    logic                  mode;
    logic [N-1:0]          a;
    logic                  load;
    logic [N-1:0]          last;
    logic [PRESCALE_W-1:0] div;

    logic [(1<<N)-1:0]     y;
    logic [N-1:0]          idx;
    logic                  busy;
    logic                  wrap;

    modport master (
        output en, mode, a, load, last, div,
        input  y, idx, busy, wrap
    );

    modport slave (
        input  en, mode, a, load, last, div,
        output y, idx, busy, wrap
    );
endinterface

// File: rtl/decn_scan.sv
// Registered N-to-2^N one-hot decoder with direct-load and auto-scan modes.
// Define DECN_SCAN_EN to build the scan sequencer; otherwise a registered enable decoder with load.
module decn_scan #(
    parameter int N          = 3,
    parameter int PRESCALE_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    decn_scan_if.slave bus
);
    localparam int W = 1 << N;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [N-1:0]          idx_reg, idx_next;
    logic [PRESCALE_W-1:0] pre_reg, pre_next;
    logic [W-1:0]          y_reg, y_next;
    logic                  busy_reg, busy_next;
    logic                  wrap_reg, wrap_next;
    logic                  mode_eff;
    logic [W-1:0]          onehot;

`ifdef DECN_SCAN_EN
    assign mode_eff = bus.mode;
`else
    assign mode_eff = 1'b0;
    logic unused_scan;
    assign unused_scan = ^{bus.mode, bus.last, bus.div, pre_reg, state_reg};
`endif

    always_comb begin
        state_next = ST_OFF;
        if (bus.en) begin
            state_next = mode_eff ? ST_SCAN : ST_DIRECT;
        end
    end

    // Outputs are registered, so everything here describes the state being entered.
    always_comb begin
        idx_next  = idx_reg;
        pre_next  = '0;
        wrap_next = 1'b0;
        case (state_next)
            ST_DIRECT: begin
                if (bus.load) begin
                    idx_next = bus.a;
                end
            end
`ifdef DECN_SCAN_EN
            ST_SCAN: begin
                if ((state_reg != ST_SCAN) || bus.load) begin
                    // Entry or explicit jump restarts the dwell; load outranks the step.
                    idx_next = bus.load ? bus.a : '0;
                end else if (pre_reg == bus.div) begin
                    if (idx_reg >= bus.last) begin
                        idx_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    pre_next = pre_reg + 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dec
            assign onehot[gi] = (idx_next == N'(gi));
        end
    endgenerate

    always_comb begin
        y_next = '0;
        if (state_next != ST_OFF) begin
            y_next = onehot;
        end
`ifdef DECN_SCAN_EN
        busy_next = (state_next == ST_SCAN);
`else
        busy_next = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_OFF;
            idx_reg   <= '0;
            pre_reg   <= '0;
            y_reg     <= '0;
            busy_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            pre_reg   <= pre_next;
            y_reg     <= y_next;
            busy_reg  <= busy_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign bus.y    = y_reg;
    assign bus.idx  = idx_reg;
    assign bus.busy = busy_reg;
    assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_decn_scan.sv
// Self-checking bench for decn_scan: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_decn_scan;
    localparam int N  = 3;
    localparam int PW = 8;
    localparam int M_OFF = 0, M_DIR = 1, M_SCAN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decn_scan_if #(.N(N), .PRESCALE_W(PW)) bus ();
    decn_scan #(.N(N), .PRESCALE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_st, m_idx, m_pre;
    bit m_wrap;

`ifdef DECN_SCAN_EN
    localparam bit HAS_SCAN = 1'b1;
`else
    localparam bit HAS_SCAN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = M_OFF;
        m_idx  = 0;
        m_pre  = 0;
        m_wrap = 1'b0;
    endtask

    // Applies one clock edge's worth of the operating rules to the model.
    task automatic model_step();
        int  target;
        bit  scan_req;
        scan_req = HAS_SCAN && (bus.mode == 1'b1);
        if (!bus.en)      target = M_OFF;
        else if (scan_req) target = M_SCAN;
        else              target = M_DIR;
        m_wrap = 1'b0;
        if (target == M_OFF) begin
            m_pre = 0;
        end else if (target == M_DIR) begin
            m_pre = 0;
            if (bus.load) m_idx = int'(bus.a);
        end else begin
            if (m_st != M_SCAN || bus.load) begin
                m_idx = bus.load ? int'(bus.a) : 0;
                m_pre = 0;
            end else if (m_pre == int'(bus.div)) begin
                m_pre = 0;
                if (m_idx >= int'(bus.last)) begin
                    m_idx  = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_pre = (m_pre + 1) % (1 << PW);
            end
        end
        m_st = target;
    endtask

    task automatic check_model(input string tag);
        logic [63:0] exp_y;
        exp_y = (m_st == M_OFF) ? 64'd0 : (64'd1 << m_idx);
        chk({tag, "_y"},    64'(bus.y),    exp_y);
        chk({tag, "_idx"},  64'(bus.idx),  64'(m_idx));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(m_st == M_SCAN));
        chk({tag, "_wrap"}, 64'(bus.wrap), 64'(m_wrap));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    initial begin
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        bus.a    = '0;
        bus.load = 1'b0;
        bus.last = '0;
        bus.div  = '0;
        model_reset();

        // Reset held across a couple of edges
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Direct decode sweep
        bus.en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.load = 1'b1;
            bus.a    = N'(k);
            step("sweep");
            chk("sweep_const_y", 64'(bus.y), 64'd1 << k);
        end
        bus.a = 3'd5;
        bus.en = 1'b0;
        step("off");
        chk("off_const_y", 64'(bus.y), 64'd0);
        bus.load = 1'b0;

`ifdef DECN_SCAN_EN
        // Scan rate and wrap: last=4, div=2
        bus.en   = 1'b1;
        bus.mode = 1'b1;
        bus.last = 3'd4;
        bus.div  = 8'd2;
        for (int t = 0; t < 18; t++) begin
            step("scan");
            chk("scan_const_idx",  64'(bus.idx),  64'((t / 3) % 5));
            chk("scan_const_wrap", 64'(bus.wrap), 64'(t == 15));
            chk("scan_const_busy", 64'(bus.busy), 64'd1);
        end

        // Jump on a terminal-count edge, then single-cycle steps
        bus.load = 1'b1;
        bus.a    = 3'd6;
        bus.last = 3'd7;
        step("jump");
        chk("jump_const_idx", 64'(bus.idx), 64'd6);
        bus.load = 1'b0;
        bus.div  = 8'd0;
        step("jump");
        chk("jump_const_idx7", 64'(bus.idx), 64'd7);
        step("jump");
        chk("jump_const_idx0", 64'(bus.idx), 64'd0);
        chk("jump_const_wrap", 64'(bus.wrap), 64'd1);
        step("jump");
        chk("jump_const_idx1", 64'(bus.idx), 64'd1);
        chk("jump_const_nowrap", 64'(bus.wrap), 64'd0);

        // Lower last below the current index, then last=0
        bus.load = 1'b1;
        bus.a    = 3'd5;
        step("lower");
        bus.load = 1'b0;
        bus.last = 3'd2;
        step("lower");
        chk("lower_const_idx",  64'(bus.idx),  64'd0);
        chk("lower_const_wrap", 64'(bus.wrap), 64'd1);
        bus.last = 3'd0;
        bus.div  = 8'd1;
        for (int t = 0; t < 6; t++) begin
            step("last0");
            chk("last0_const_idx",  64'(bus.idx),  64'd0);
            chk("last0_const_wrap", 64'(bus.wrap), 64'(t % 2 == 1));
        end
        bus.div = 8'd3;
        bus.last = 3'd7;
`else
        // Mode is ignored without the scan feature
        bus.en   = 1'b1;
        bus.mode = 1'b1;
        bus.load = 1'b1;
        bus.a    = 3'd3;
        step("nomacro");
        chk("nomacro_const_y",    64'(bus.y),    64'h08);
        chk("nomacro_const_busy", 64'(bus.busy), 64'd0);
        chk("nomacro_const_wrap", 64'(bus.wrap), 64'd0);
        bus.load = 1'b0;
        bus.div  = 8'd3;
`endif

        // Asynchronous reset while running
        bus.en   = 1'b1;
        bus.mode = 1'b1;
        for (int t = 0; t < 5; t++) step("prerst");
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        chk("async_rst_const_y", 64'(bus.y), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
            bus.load = ($urandom_range(0, 5) == 0);
            bus.a    = N'($urandom);
            if ($urandom_range(0, 9) == 0) bus.last = N'($urandom);
            if ($urandom_range(0, 29) == 0) bus.div = PW'($urandom_range(0, 3));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decn_scan.md
# decn_scan

Parametrised, registered N-to-2^N one-hot decoder with an auto-scan sequencer. In direct mode it latches a select index and drives the matching one-hot output; in scan mode it steps the active output through indices 0..last at a programmable rate, for digit/row multiplexing and channel strobing. All outputs are registered, and the block sits between control logic and the one-hot enables of downstream drivers.

## Interface
Parameters:
- N, 3, select width; output width is 2^N; legal range 1..6
- PRESCALE_W, 8, width of the step-rate divider

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; 0 forces y to all-zero
- mode  input  1  0 = direct, 1 = scan
- a  input  N  select index (direct) or scan jump target
- load  input  1  one-cycle strobe to capture a
- last  input  N  final scan index before wrap (inclusive)
- div  input  PRESCALE_W  scan step period minus one, in clk cycles
- y  output  2^N  one-hot decoded output
- idx  output  N  current active index
- busy  output  1  high while in SCAN state
- wrap  output  1  one-cycle pulse when scan wraps to index 0

## Operation
- State machine, evaluated each clk: OFF, DIRECT, SCAN.
  - Any state with en=0 goes to OFF.
  - With en=1 and mode=0, next state is DIRECT.
  - With en=1 and mode=1, next state is SCAN.
- OFF: y=0, busy=0, prescaler cleared, idx holds its value.
- DIRECT:
  - load=1 captures a into idx.
  - y = 1<<idx.
  - Prescaler is held at 0.
- SCAN:
  - Entering from OFF or DIRECT sets idx=0 and clears the prescaler, unless load=1 in the same cycle, in which case idx=a.
  - The prescaler counts 0..div. At terminal count (prescaler==div) it returns to 0 and idx advances.
  - idx advance: if idx>=last, idx becomes 0 and wrap pulses; otherwise idx becomes idx+1.
  - div=0 steps every cycle.
  - load=1 while in SCAN sets idx=a and clears the prescaler. Load has priority over the step.
  - last=0 holds idx at 0, and wrap pulses at every terminal count.
  - If last is lowered below the current idx, the next terminal count wraps to 0 and pulses wrap.
- y is always exactly one-hot or all-zero.
- Arithmetic: the prescaler is PRESCALE_W bits and idx is N bits. No overflow is possible because of the idx>=last compare.
- Asynchronous reset may arrive mid-scan. Reset state: OFF, y=0, idx=0, busy=0, wrap=0, prescaler=0.

## Timing
- All outputs are registered with 1-cycle latency. An input sampled at edge k is visible after edge k.
- load in DIRECT: y reflects a in the cycle after the load edge.
- Scan step period is div+1 cycles. Dwell time on each index is exactly div+1 cycles, including index 0 after a wrap.
- wrap is asserted in the same cycle that idx=0 first appears after a wrap, for one cycle only.
- busy rises in the cycle after en=1 && mode=1 is sampled and falls in the cycle after either input drops.
- en deasserted: y=0 on the next cycle, regardless of load.
- Reset release: the first active edge already evaluates the state transition.

## Configuration
- DECN_SCAN_EN
  - Defined: full behaviour as above.
  - Undefined:
    - The SCAN state, prescaler, last and div logic are removed.
    - mode is ignored and treated as 0.
    - busy and wrap are tied to 0.
    - The ports remain present so the interface is unchanged.
    - The block is a registered enable decoder with load.

## Test plan
- Reset mid-scan: N=3, div=3, assert rst_n=0 asynchronously -> y=0, idx=0, busy=0, wrap=0 immediately, without waiting for a clk edge.
- Direct decode sweep: en=1, mode=0, load a=0..7 one per cycle -> y=00000001..10000000 one cycle after each load; en=0 -> y=00000000 next cycle.
- Scan rate and wrap: mode=1, last=4, div=2 -> idx sequence 0,1,2,3,4,0, each held 3 cycles; wrap high exactly 1 cycle at each return to 0; busy=1 throughout.
- Jump and priority: during SCAN, load with a=6 on a terminal-count cycle, last=7, div=0 -> idx=6 next cycle, then 7, 0 (wrap), 1.
- Last lowered: scanning at idx=5, set last=2 -> next step gives idx=0 with wrap pulse; last=0 -> idx stays 0 and wrap pulses every div+1 cycles.
- Macro off: build without DECN_SCAN_EN, mode=1 with load a=3 -> y=00001000, busy=0, wrap=0.
